mult_12_arbiter: RTL and testbench

//   Shares one pipelined 12-bit float multiplier (mult_12: 1 sign, 5 exp, 6 mant) among NUM_REQ requesters.
//   - Round-robin arbitration with a valid/ready handshake per requester.
//   - Registers the winning operand pair onto the multiplier inputs.
//   - Carries a requester tag alongside the multiplier pipeline and steers each result back to its owner.
//   - Caps in-flight ops per requester at MAX_OUT.

---
 rtl/mult_12_arbiter.sv | 118 +++++++++++
 tb/tb_mult_12_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_12_arbiter.sv
// Round-robin front end that shares one pipelined mult_12 among NUM_REQ requesters,
// tracking each op's owner through the multiplier latency and capping ops in flight per requester.
module mult_12_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 3,
  parameter int MAX_OUT  = 2,
  parameter int ID_W     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*12-1:0]   req_a_i,
  input  logic [NUM_REQ*12-1:0]   req_b_i,
  output logic [11:0]             mult_a_o,
  output logic [11:0]             mult_b_o,
  input  logic [11:0]             mult_result_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [11:0]             rsp_data_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic                    busy_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]                  ptr;
  logic [NUM_REQ-1:0][CNT_W-1:0]    out_cnt;
  logic [NUM_REQ-1:0]               eligible;
  logic [NUM_REQ-1:0]               grant;
  logic [ID_W-1:0]                  grant_id;
  logic                             grant_any;
  logic [11:0]                      sel_a;
  logic [11:0]                      sel_b;
  logic [MULT_LAT:0]                tag_vld_p;
  logic [MULT_LAT:0][ID_W-1:0]      tag_id_p;
  logic                             rsp_vld;

  // Saturating in-flight counter: simultaneous issue and retire cancel out.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec && cnt != CNT_W'(MAX_OUT))
      nxt = cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)
      nxt = cnt - CNT_W'(1);
    return nxt;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid_i[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
  end

  // Grant search starts just past the last winner and wraps, so the winner drops to lowest priority.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a_i[12*i +: 12];
        sel_b = req_b_i[12*i +: 12];
      end
    end
  end

  assign req_ready_o = grant;

  // Stage 0 is the issue register; stage MULT_LAT lines up with mult_result_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mult_a_o  <= '0;
      mult_b_o  <= '0;
      tag_vld_p <= '0;
      tag_id_p  <= '0;
      ptr       <= ID_W'(NUM_REQ - 1);
      out_cnt   <= '0;
    end else begin
      mult_a_o  <= sel_a;
      mult_b_o  <= sel_b;
      tag_vld_p <= {tag_vld_p[MULT_LAT-1:0], grant_any};
      tag_id_p  <= {tag_id_p[MULT_LAT-1:0], grant_id};
      if (grant_any)
        ptr <= grant_id;
      for (int i = 0; i < NUM_REQ; i++)
        out_cnt[i] <= cnt_step(out_cnt[i], grant[i], rsp_valid_o[i]);
    end
  end

  // Response stage: results carry no backpressure, so the tag is steered straight out.
  assign rsp_vld = tag_vld_p[MULT_LAT];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_o[i] = rsp_vld && (tag_id_p[MULT_LAT] == ID_W'(i));
  end

  assign rsp_id_o   = rsp_vld ? tag_id_p[MULT_LAT] : '0;
  assign rsp_data_o = mult_result_i;
  assign busy_o     = (|tag_vld_p) || grant_any;

endmodule

// File: tb/tb_mult_12_arbiter.sv
// Bench for mult_12_arbiter: a behavioural 3-cycle mult_12 stand-in plus a queue-based
// reference of arbitration, in-flight limits and response ordering.
module tb_mult_12_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int MULT_LAT = 3;
  localparam int MAX_OUT  = 2;
  localparam int ID_W     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  ready;
  logic [47:0] req_a, req_b;
  logic [11:0] mult_a, mult_b, mult_res;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  always #5 clk = ~clk;

  mult_12_arbiter #(.NUM_REQ(NUM_REQ), .MULT_LAT(MULT_LAT), .MAX_OUT(MAX_OUT), .ID_W(ID_W)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready),
    .req_a_i(req_a), .req_b_i(req_b), .mult_a_o(mult_a), .mult_b_o(mult_b),
    .mult_result_i(mult_res), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_id_o(rsp_id), .busy_o(busy)
  );

  // 1/5/6 float multiply, bias 15, truncating, zero exponent treated as zero.
  function automatic logic [11:0] fmul(input logic [11:0] a, input logic [11:0] b);
    logic s;
    int ea, eb, e, m;
    s  = a[11] ^ b[11];
    ea = int'(a[10:6]);
    eb = int'(b[10:6]);
    if (ea == 0 || eb == 0) return 12'h000;
    m = (64 + int'(a[5:0])) * (64 + int'(b[5:0]));
    e = ea + eb - 15;
    if (m >= 8192) begin m = m >> 7; e++; end
    else m = m >> 6;
    if (e <= 0) return 12'h000;
    if (e >= 31) return {s, 5'h1e, 6'h3f};
    return {s, 5'(e), 6'(m)};
  endfunction

  logic [11:0] m1, m2, m3;
  always @(posedge clk) begin
    m1 <= fmul(mult_a, mult_b);
    m2 <= m1;
    m3 <= m2;
  end
  assign mult_res = m3;

  typedef struct {int id; logic [11:0] d; int due;} op_t;
  op_t pend[$];
  int  cnt_m[NUM_REQ];
  int  ptr_m;
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  logic [3:0]  exp_ready, exp_rv;
  logic [1:0]  exp_id;
  logic [11:0] exp_data, exp_ma, exp_mb;
  logic        exp_busy;

  function automatic logic [11:0] rnd_op();
    if ($urandom_range(9) == 0) return 12'h000;
    return {1'($urandom), 5'($urandom_range(8, 22)), 6'($urandom)};
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < NUM_REQ; i++) cnt_m[i] = 0;
    ptr_m  = NUM_REQ - 1;
    exp_ma = '0;
    exp_mb = '0;
  endtask

  task automatic eval();
    exp_ready = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int r = (ptr_m + off) % NUM_REQ;
      if (exp_ready == 0 && req_valid[r] && cnt_m[r] < MAX_OUT) exp_ready[r] = 1'b1;
    end
    exp_rv = '0; exp_id = '0; exp_data = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv[pend[0].id] = 1'b1;
      exp_id   = 2'(pend[0].id);
      exp_data = pend[0].d;
    end
    exp_busy = (pend.size() > 0) || (exp_ready != 0);
  endtask

  task automatic tick(output int acc);
    int g;
    g = -1;
    for (int i = 0; i < NUM_REQ; i++) if (exp_ready[i] && req_valid[i]) g = i;
    @(posedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc - 1) begin
      cnt_m[pend[0].id]--;
      void'(pend.pop_front());
    end
    exp_ma = '0; exp_mb = '0;
    if (g >= 0) begin
      cnt_m[g]++;
      ptr_m  = g;
      exp_ma = req_a[12*g +: 12];
      exp_mb = req_b[12*g +: 12];
      pend.push_back('{g, fmul(req_a[12*g +: 12], req_b[12*g +: 12]), cyc + MULT_LAT});
    end
    acc = g;
    #1;
  endtask

  task automatic drive(input logic [3:0] mask, input int acc, input bit force_on, input int drop_pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!mask[i]) req_valid[i] = 1'b0;
      else if (req_valid[i] && acc != i) begin
        if (!force_on && $urandom_range(99) < drop_pct) req_valid[i] = 1'b0;
      end else begin
        req_valid[i]       = force_on ? 1'b1 : 1'($urandom);
        req_a[12*i +: 12]  = rnd_op();
        req_b[12*i +: 12]  = rnd_op();
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    eval();
    vectors++;
    if (ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_id !== 2'd0 || busy !== 1'b0 ||
        mult_a !== 12'h0 || mult_b !== 12'h0) begin
      miscompares++;
      $display("FAIL reset ready/rv/id/busy/a/b=%b/%b/%0d/%b/%h/%h expected all zero",
               ready, rsp_valid, rsp_id, busy, mult_a, mult_b);
    end
  endtask

  task automatic test_single_op();
    int acc, k;
    do_reset();
    req_a = '0; req_b = '0;
    req_valid = 4'b0010;
    req_a[12 +: 12] = 12'h3C0;
    req_b[12 +: 12] = 12'h400;
    #1;
    eval();
    vectors++;
    if (ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_ready got %b expected 0010", ready);
    end
    tick(acc);
    k = cyc;
    req_valid = '0;
    repeat (6) begin
      #1;
      eval();
      vectors++;
      if ({ready, rsp_valid, rsp_id, busy} !== {exp_ready, exp_rv, exp_id, exp_busy} ||
          mult_a !== exp_ma || mult_b !== exp_mb) begin
        miscompares++;
        $display("FAIL single cyc=%0d ready/rv/id/busy/a/b=%b/%b/%0d/%b/%h/%h expected %b/%b/%0d/%b/%h/%h",
                 cyc, ready, rsp_valid, rsp_id, busy, mult_a, mult_b,
                 exp_ready, exp_rv, exp_id, exp_busy, exp_ma, exp_mb);
      end
      if (cyc == k + MULT_LAT) begin
        vectors++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 12'h400 || rsp_id !== 2'd1) begin
          miscompares++;
          $display("FAIL single_rsp got rv=%b data=%h id=%0d expected 0010/400/1",
                   rsp_valid, rsp_data, rsp_id);
        end
      end
      tick(acc);
    end
  endtask

  task automatic test_all_valid();
    int acc, n;
    do_reset();
    acc = -1;
    n = 0;
    repeat (32) begin
      drive(4'b1111, acc, 1'b1, 0);
      #1;
      eval();
      vectors++;
      if ({ready, rsp_valid, rsp_id, busy} !== {exp_ready, exp_rv, exp_id, exp_busy} ||
          mult_a !== exp_ma || mult_b !== exp_mb) begin
        miscompares++;
        $display("FAIL all_valid cyc=%0d ready/rv/id/busy/a/b=%b/%b/%0d/%b/%h/%h expected %b/%b/%0d/%b/%h/%h",
                 cyc, ready, rsp_valid, rsp_id, busy, mult_a, mult_b,
                 exp_ready, exp_rv, exp_id, exp_busy, exp_ma, exp_mb);
      end
      if (exp_rv != 0) begin
        vectors++;
        if (rsp_data !== exp_data) begin
          miscompares++;
          $display("FAIL all_valid_data cyc=%0d got %h expected %h", cyc, rsp_data, exp_data);
        end
      end
      vectors++;
      if (ready !== 4'(1 << (n % NUM_REQ))) begin
        miscompares++;
        $display("FAIL all_valid_order step=%0d got %b expected %b", n, ready, 4'(1 << (n % NUM_REQ)));
      end
      n++;
      tick(acc);
    end
  endtask

  task automatic test_max_out();
    int acc, inflight, same, low;
    do_reset();
    acc = -1; inflight = 0; same = 0; low = 0;
    repeat (24) begin
      drive(4'b0001, acc, 1'b1, 0);
      #1;
      eval();
      vectors++;
      if ({ready, rsp_valid, rsp_id, busy} !== {exp_ready, exp_rv, exp_id, exp_busy} ||
          mult_a !== exp_ma || mult_b !== exp_mb) begin
        miscompares++;
        $display("FAIL max_out cyc=%0d ready/rv/id/busy/a/b=%b/%b/%0d/%b/%h/%h expected %b/%b/%0d/%b/%h/%h",
                 cyc, ready, rsp_valid, rsp_id, busy, mult_a, mult_b,
                 exp_ready, exp_rv, exp_id, exp_busy, exp_ma, exp_mb);
      end
      if (exp_rv != 0) begin
        vectors++;
        if (rsp_data !== exp_data) begin
          miscompares++;
          $display("FAIL max_out_data cyc=%0d got %h expected %h", cyc, rsp_data, exp_data);
        end
      end
      if (ready[0] && rsp_valid[0]) same++;
      if (!ready[0]) low++;
      inflight += (ready[0] && req_valid[0]) ? 1 : 0;
      inflight -= rsp_valid[0] ? 1 : 0;
      vectors++;
      if (inflight > MAX_OUT || inflight < 0) begin
        miscompares++;
        $display("FAIL max_out_inflight cyc=%0d got %0d expected 0..%0d", cyc, inflight, MAX_OUT);
      end
      tick(acc);
    end
    vectors++;
    if (same == 0 || low == 0) begin
      miscompares++;
      $display("FAIL max_out_events got same_cycle=%0d ready_low=%0d expected both nonzero", same, low);
    end
  endtask

  task automatic test_reset_inflight();
    int acc, pulses;
    do_reset();
    acc = -1;
    repeat (3) begin
      drive(4'b1111, acc, 1'b1, 0);
      #1;
      eval();
      vectors++;
      if ({ready, rsp_valid, rsp_id, busy} !== {exp_ready, exp_rv, exp_id, exp_busy}) begin
        miscompares++;
        $display("FAIL rst_fill cyc=%0d ready/rv/id/busy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 cyc, ready, rsp_valid, rsp_id, busy, exp_ready, exp_rv, exp_id, exp_busy);
      end
      tick(acc);
    end
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    vectors++;
    if (busy !== 1'b0 || mult_a !== 12'h0 || rsp_valid !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_flight got busy=%b a=%h rv=%b expected 0/000/0000", busy, mult_a, rsp_valid);
    end
    pulses = 0;
    repeat (8) begin
      #1;
      eval();
      if (rsp_valid != 0) pulses++;
      tick(acc);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL rst_pulses got %0d expected 0", pulses);
    end
    req_valid = 4'b1111;
    #1;
    eval();
    vectors++;
    if (ready !== 4'b0001 || ready !== exp_ready) begin
      miscompares++;
      $display("FAIL rst_first_grant got %b expected 0001", ready);
    end
    tick(acc);
    req_valid = '0;
  endtask

  task automatic test_zero_operand();
    int acc, zseen;
    bit zsent;
    acc = -1; zseen = 0; zsent = 1'b0;
    repeat (12) begin
      drive(4'b1000, acc, 1'b0, 0);
      if (acc == 2) zsent = 1'b1;
      if (!zsent) begin
        req_valid[2]     = 1'b1;
        req_a[24 +: 12]  = 12'h000;
        req_b[24 +: 12]  = 12'h5C0;
      end else req_valid[2] = 1'b0;
      #1;
      eval();
      vectors++;
      if ({ready, rsp_valid, rsp_id, busy} !== {exp_ready, exp_rv, exp_id, exp_busy} ||
          mult_a !== exp_ma || mult_b !== exp_mb) begin
        miscompares++;
        $display("FAIL zero cyc=%0d ready/rv/id/busy/a/b=%b/%b/%0d/%b/%h/%h expected %b/%b/%0d/%b/%h/%h",
                 cyc, ready, rsp_valid, rsp_id, busy, mult_a, mult_b,
                 exp_ready, exp_rv, exp_id, exp_busy, exp_ma, exp_mb);
      end
      if (exp_rv != 0) begin
        vectors++;
        if (rsp_data !== exp_data) begin
          miscompares++;
          $display("FAIL zero_data cyc=%0d got %h expected %h", cyc, rsp_data, exp_data);
        end
      end
      if (rsp_valid[2]) begin
        zseen++;
        vectors++;
        if (rsp_data !== 12'h000 || rsp_id !== 2'd2) begin
          miscompares++;
          $display("FAIL zero_rsp got data=%h id=%0d expected 000/2", rsp_data, rsp_id);
        end
      end
      tick(acc);
    end
    vectors++;
    if (zseen != 1) begin
      miscompares++;
      $display("FAIL zero_count got %0d expected 1", zseen);
    end
  endtask

  task automatic test_random();
    int acc;
    acc = -1;
    repeat (300) begin
      drive(4'b1111, acc, 1'b0, 10);
      #1;
      eval();
      vectors++;
      if ({ready, rsp_valid, rsp_id, busy} !== {exp_ready, exp_rv, exp_id, exp_busy} ||
          mult_a !== exp_ma || mult_b !== exp_mb) begin
        miscompares++;
        $display("FAIL random cyc=%0d ready/rv/id/busy/a/b=%b/%b/%0d/%b/%h/%h expected %b/%b/%0d/%b/%h/%h",
                 cyc, ready, rsp_valid, rsp_id, busy, mult_a, mult_b,
                 exp_ready, exp_rv, exp_id, exp_busy, exp_ma, exp_mb);
      end
      if (exp_rv != 0) begin
        vectors++;
        if (rsp_data !== exp_data) begin
          miscompares++;
          $display("FAIL random_data cyc=%0d got %h expected %h", cyc, rsp_data, exp_data);
        end
      end
      tick(acc);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    model_clear();
    test_reset();
    test_single_op();
    test_all_valid();
    test_max_out();
    test_reset_inflight();
    test_zero_operand();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
